// File: rtl/sr_bank_driver.sv
// Serial driver for a bank of SR flip-flops: walks one bit per cycle through the
// excitation table, lets the bank settle, then verifies the feedback against the target.
module sr_bank_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o,
  input  logic [WIDTH-1:0] fb_q,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] target, target_nx;
  logic [WIDTH-1:0] model, model_nx;
  logic [WIDTH-1:0] s_nx, r_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic             drv_en;
  logic [IW-1:0]    drv_idx;
  logic [WIDTH-1:0] drv_t;
  logic             match;

  assign match = (fb_q == target);

  // s_o/r_o are registered, so each edge precomputes the command for the bit
  // that the next cycle will own; state, idx and the command line up in time.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    model_nx  = model;
    idx_nx    = idx;
    drv_en    = 1'b0;
    drv_idx   = '0;
    drv_t     = target;
    s_nx      = '0;
    r_nx      = '0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          target_nx = in_data;
          idx_nx    = '0;
          state_nx  = DRIVE;
          drv_en    = 1'b1;
          drv_t     = in_data;
        end
      end
      DRIVE: begin
        if (idx == IW'(WIDTH - 1)) begin
          state_nx = SETTLE;
        end else begin
          idx_nx  = idx + 1'b1;
          drv_en  = 1'b1;
          drv_idx = idx + 1'b1;
        end
      end
      SETTLE: state_nx = CHECK;
      CHECK: begin
        // on mismatch, resync the model to what the bank really holds
        model_nx = match ? target : fb_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (drv_en) begin
      s_nx[drv_idx] =  drv_t[drv_idx] & ~model[drv_idx];
      r_nx[drv_idx] = ~drv_t[drv_idx] &  model[drv_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= '0;
      model    <= '0;
      idx      <= '0;
      s_o      <= '0;
      r_o      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      target   <= target_nx;
      model    <= model_nx;
      idx      <= idx_nx;
      s_o      <= s_nx;
      r_o      <= r_nx;
      in_ready <= (state_nx == IDLE);
      busy     <= (state_nx != IDLE);
    end
  end

  // fb_q only matters while in CHECK; both pulses are forced low elsewhere
  assign done = (state == CHECK) &&  match;
  assign err  = (state == CHECK) && !match;

endmodule
